// File: rtl/id_issue_stage_pkg.sv
// Shared types and constants for the ID/issue stage: decoded-control field widths,
// the ID/EX operand bundle, and scoreboard sizing.
package id_issue_stage_pkg;

    localparam int CORE_XLEN       = 32;
    localparam int CORE_REG_ADDR_W = 5;

    typedef enum logic [7:0] {
        ALU_ADD = 8'h00, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASS_B
    } alu_opcode_e;

    typedef enum logic [7:0] {
        LSU_NONE = 8'h00, LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU,
        LSU_SB, LSU_SH, LSU_SW
    } load_store_func_code_e;

    typedef enum logic [3:0] {
        WB_ALU = 4'h0, WB_MEM, WB_PC4, WB_IMM
    } write_back_mux_selector_e;

    typedef enum logic [3:0] {
        PC_NEXT = 4'h0, PC_BRANCH, PC_JAL, PC_JALR
    } pc_mux_e;

    localparam int CTRL_W_DEFAULT = $bits(alu_opcode_e) + $bits(load_store_func_code_e)
                                  + $bits(write_back_mux_selector_e) + $bits(pc_mux_e);

    localparam logic [CORE_REG_ADDR_W-1:0] REG_X0 = '0;
    localparam int SB_DEPTH = 2 ** CORE_REG_ADDR_W;

    typedef struct packed {
        logic [CORE_XLEN-1:0]       pc;
        logic [CTRL_W_DEFAULT-1:0]  ctrl;
        logic [CORE_XLEN-1:0]       opa;
        logic [CORE_XLEN-1:0]       opb;
        logic [CORE_REG_ADDR_W-1:0] rd;
        logic                       rd_we;
        logic                       is_load;
    } idex_bundle_t;

endpackage

// File: rtl/id_issue_stage_scoreboard.sv
// Pending-register-write scoreboard: one bit per architectural register, two read
// ports, and a set that wins over a same-cycle clear. x0 is never pending.
module reg_scoreboard #(
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              pend_a,
    output logic              pend_b
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    // NOTE: start from the held value so every path assigns pend_d and no latch is inferred.
    always_comb begin
        pend_d = pend_q;
        if (clr_en) pend_d[clr_addr] = 1'b0;
        if (set_en) pend_d[set_addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    // NOTE: this small bit-array is reset explicitly; a clean "nothing pending" state is architectural.
    // NOTE: state registers take non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign pend_a = pend_q[rd_addr_a];
    assign pend_b = pend_q[rd_addr_b];

endmodule

// File: rtl/id_issue_stage.sv
// ID/issue stage: valid/ready buffer (main + optional skid entry) between decode and EX,
// with a register scoreboard that raises load-use / RAW hazard stalls.
module id_issue_stage
    import id_issue_stage_pkg::*;
#(
    parameter int XLEN             = CORE_XLEN,
    parameter int REG_ADDR_W       = CORE_REG_ADDR_W,
    parameter int CTRL_W           = CTRL_W_DEFAULT,
    parameter int SKID_EN          = 1,
    parameter int LOAD_ONLY_HAZARD = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [XLEN-1:0]       in_opa,
    input  logic [XLEN-1:0]       in_opb,
    input  logic [REG_ADDR_W-1:0] in_rs1,
    input  logic [REG_ADDR_W-1:0] in_rs2,
    input  logic                  in_rs1_used,
    input  logic                  in_rs2_used,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_rd_we,
    input  logic                  in_is_load,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_pc,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [XLEN-1:0]       out_opa,
    output logic [XLEN-1:0]       out_opb,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_rd_we,
    output logic                  out_is_load,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall_op
);
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [CTRL_W-1:0]     ctrl;
        logic [XLEN-1:0]       opa;
        logic [XLEN-1:0]       opb;
        logic [REG_ADDR_W-1:0] rd;
        logic                  rd_we;
        logic                  is_load;
    } entry_t;

    entry_t in_entry, main_q, skid_q;
    logic   main_v, skid_v;
    logic   acc, leave, space, hazard;
    logic   main_marks, skid_marks;
    logic   pend_1, pend_2, m1, m2;

    assign in_entry = '{pc: in_pc, ctrl: in_ctrl, opa: in_opa, opb: in_opb,
                        rd: in_rd, rd_we: in_rd_we, is_load: in_is_load};

    // An entry "marks" if its departure will set its destination pending.
    assign main_marks = main_q.rd_we && (main_q.rd != '0) && (main_q.is_load || LOAD_ONLY_HAZARD == 0);
    assign skid_marks = skid_q.rd_we && (skid_q.rd != '0) && (skid_q.is_load || LOAD_ONLY_HAZARD == 0);

    assign m1 = in_rs1_used && (in_rs1 != '0) &&
                (pend_1 || (main_v && main_marks && main_q.rd == in_rs1)
                        || (skid_v && skid_marks && skid_q.rd == in_rs1));
    assign m2 = in_rs2_used && (in_rs2 != '0) &&
                (pend_2 || (main_v && main_marks && main_q.rd == in_rs2)
                        || (skid_v && skid_marks && skid_q.rd == in_rs2));

    assign hazard   = in_valid && (m1 || m2);
    assign space    = (SKID_EN != 0) ? !skid_v : (!main_v || out_ready);
    assign in_ready = !hazard && space;
    assign stall_op = in_valid && !in_ready;
    assign acc      = in_valid && in_ready && !flush;
    assign leave    = main_v && out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (!main_v || leave) begin
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= acc;
                if (acc) skid_q <= in_entry;
            end else begin
                main_v <= acc;
                if (acc) main_q <= in_entry;
            end
        end else if (acc) begin
            // Main is stalled by EX; park the new instruction behind it.
            skid_q <= in_entry;
            skid_v <= 1'b1;
        end
    end

    reg_scoreboard #(.ADDR_W(REG_ADDR_W)) u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (leave && !flush && main_marks),
        .set_addr  (main_q.rd),
        .clr_en    (wb_valid && (wb_rd != '0)),
        .clr_addr  (wb_rd),
        .rd_addr_a (in_rs1),
        .rd_addr_b (in_rs2),
        .pend_a    (pend_1),
        .pend_b    (pend_2)
    );

    assign out_valid   = main_v;
    assign out_pc      = main_q.pc;
    assign out_ctrl    = main_q.ctrl;
    assign out_opa     = main_q.opa;
    assign out_opb     = main_q.opb;
    assign out_rd      = main_q.rd;
    assign out_rd_we   = main_q.rd_we;
    assign out_is_load = main_q.is_load;

endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: flow/backpressure vector table plus hand-written
// load-use, set/clear, flush and async-reset sequences, with an in-order output scoreboard.
module tb_id_issue_stage;
    import id_issue_stage_pkg::*;

    logic        clock, reset;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_opa, in_opb;
    logic [23:0] in_ctrl;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rs1_used, in_rs2_used, in_rd_we, in_is_load;
    logic        flush, out_valid, out_ready;
    logic [31:0] out_pc, out_opa, out_opb;
    logic [23:0] out_ctrl;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_is_load;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        stall_op;

    id_issue_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_ctrl(in_ctrl),
        .in_opa(in_opa), .in_opb(in_opb), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_used(in_rs1_used), .in_rs2_used(in_rs2_used), .in_rd(in_rd),
        .in_rd_we(in_rd_we), .in_is_load(in_is_load), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ctrl(out_ctrl),
        .out_opa(out_opa), .out_opb(out_opb), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_is_load(out_is_load), .wb_valid(wb_valid), .wb_rd(wb_rd), .stall_op(stall_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    idex_bundle_t exp_q[$];

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        ordy;
        logic        exp_ir;
        logic        exp_ov;
    } flow_vec_t;

    flow_vec_t flow[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                         input logic we, input logic ld);
        in_valid    = v;
        in_pc       = pc;
        in_ctrl     = pc[23:0] ^ 24'h5A5A5A;
        in_opa      = pc ^ 32'h1234_5678;
        in_opb      = ~pc;
        in_rs1      = rs1;
        in_rs1_used = u1;
        in_rs2      = rs2;
        in_rs2_used = u2;
        in_rd       = rd;
        in_rd_we    = we;
        in_is_load  = ld;
    endtask

    task automatic settle();
        #2;
    endtask

    // Observe handshakes just before the edge, then advance to the next negedge.
    task automatic finish_cycle();
        idex_bundle_t got, e;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                got = '{pc: out_pc, ctrl: out_ctrl, opa: out_opa, opb: out_opb,
                        rd: out_rd, rd_we: out_rd_we, is_load: out_is_load};
                if (exp_q.size() == 0) begin
                    check("unexpected_output", got.pc, 128'hDEAD);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bundle", got, e);
                end
            end
            if (in_valid && in_ready) begin
                e = '{pc: in_pc, ctrl: in_ctrl, opa: in_opa, opb: in_opb,
                      rd: in_rd, rd_we: in_rd_we, is_load: in_is_load};
                exp_q.push_back(e);
            end
        end
        @(negedge clock);
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        flow[0]  = '{1'b1, 32'h00, 1'b1, 1'b1, 1'b0};
        flow[1]  = '{1'b1, 32'h04, 1'b1, 1'b1, 1'b1};
        flow[2]  = '{1'b1, 32'h08, 1'b1, 1'b1, 1'b1};
        flow[3]  = '{1'b1, 32'h0C, 1'b1, 1'b1, 1'b1};
        flow[4]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1};
        flow[5]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0};
        flow[6]  = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b0};
        flow[7]  = '{1'b1, 32'h14, 1'b0, 1'b1, 1'b1};
        flow[8]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1};
        flow[9]  = '{1'b1, 32'h18, 1'b1, 1'b0, 1'b1};
        flow[10] = '{1'b1, 32'h18, 1'b1, 1'b1, 1'b1};
        flow[11] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1};
        flow[12] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0};

        reset = 1'b0; flush = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0;
        idle();
        @(negedge clock);
        settle();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_stall_op", stall_op, 1'b0);
        check("reset_out_pc", out_pc, 32'h0);
        check("reset_out_ctrl", out_ctrl, 24'h0);
        @(negedge clock);
        reset = 1'b1;

        // Back-to-back flow then backpressure into the skid entry.
        for (int i = 0; i < 13; i++) begin
            drive(flow[i].v, flow[i].pc, 5'd0, 1'b0, 5'd0, 1'b0, 5'((i % 7) + 1), 1'b1, 1'b0);
            out_ready = flow[i].ordy;
            settle();
            check($sformatf("flow%0d_in_ready", i), in_ready, flow[i].exp_ir);
            check($sformatf("flow%0d_out_valid", i), out_valid, flow[i].exp_ov);
            finish_cycle();
        end

        // Load-use on x5: stall through the wb cycle, release the cycle after.
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
        settle(); finish_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h104, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
            wb_valid = (i == 3); wb_rd = 5'd5;
            settle();
            check($sformatf("loaduse_stall%0d", i), stall_op, 1'b1);
            finish_cycle();
        end
        wb_valid = 1'b0;
        settle();
        check("loaduse_release", stall_op, 1'b0);
        check("loaduse_in_ready", in_ready, 1'b1);
        finish_cycle();
        idle();
        settle();
        check("loaduse_add_out", out_valid, 1'b1);
        finish_cycle();

        // Load of x7 leaves while wb clears x7: set wins.
        drive(1'b1, 32'h200, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        settle(); finish_cycle();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd7;
        settle(); finish_cycle();
        wb_valid = 1'b0;
        drive(1'b1, 32'h204, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
        settle();
        check("setclr_x7_pending", stall_op, 1'b1);
        finish_cycle();
        wb_valid = 1'b1; wb_rd = 5'd7;
        settle();
        check("setclr_wb_cycle", stall_op, 1'b1);
        finish_cycle();
        wb_valid = 1'b0;
        settle();
        check("setclr_release", stall_op, 1'b0);
        finish_cycle();
        idle();
        settle(); finish_cycle();

        // Flush with both entries full and a load handshaking at the head.
        drive(1'b1, 32'h2F0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
        settle(); finish_cycle();
        idle();
        settle(); finish_cycle();
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
        settle(); finish_cycle();
        drive(1'b1, 32'h304, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        settle();
        check("flush_fill_in_ready", in_ready, 1'b1);
        finish_cycle();
        drive(1'b1, 32'h308, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        out_ready = 1'b1; flush = 1'b1;
        settle();
        check("flush_skid_full", in_ready, 1'b0);
        finish_cycle();
        flush = 1'b0;
        drive(1'b1, 32'h30C, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_x9_kept", stall_op, 1'b1);
        finish_cycle();
        drive(1'b1, 32'h310, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        settle();
        check("flush_x10_not_marked", stall_op, 1'b0);
        finish_cycle();
        idle();
        wb_valid = 1'b1; wb_rd = 5'd9;
        settle(); finish_cycle();
        wb_valid = 1'b0;
        settle(); finish_cycle();

        // Async reset between edges with pending state and full buffer.
        drive(1'b1, 32'h400, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
        settle(); finish_cycle();
        idle();
        settle(); finish_cycle();
        out_ready = 1'b0;
        drive(1'b1, 32'h404, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
        settle(); finish_cycle();
        drive(1'b1, 32'h408, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
        settle(); finish_cycle();
        drive(1'b1, 32'h40C, 5'd12, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0);
        settle();
        check("prereset_stall", stall_op, 1'b1);
        @(negedge clock);
        #1 reset = 1'b0;
        #1;
        check("async_reset_out_valid", out_valid, 1'b0);
        check("async_reset_sb_clear", stall_op, 1'b0);
        check("async_reset_out_pc", out_pc, 32'h0);
        exp_q.delete();
        idle();
        @(negedge clock);
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h500, 5'd12, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        settle();
        check("post_reset_in_ready", in_ready, 1'b1);
        finish_cycle();
        idle();
        settle();
        check("post_reset_out_valid", out_valid, 1'b1);
        finish_cycle();
        settle(); finish_cycle();

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
